// File: rtl/water_inlet_arbiter.sv
// water_inlet_arbiter: shares a single mains water inlet among NUM_MACHINES
// washer FSMs. Round-robin grant, watchdog on each fill, and a settle gap
// between consecutive grants so that line pressure can recover.

// Per-machine sticky fault flag. Set has priority over clear.
module water_inlet_fault_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic set_i,
    input  logic clr_i,
    output logic fault_o
);

    logic fault_q;

    // Sticky flag: a set in the same cycle as a clear keeps the fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else if (set_i) begin
            fault_q <= 1'b1;
        end else if (clr_i) begin
            fault_q <= 1'b0;
        end
    end

    assign fault_o = fault_q;

endmodule

module water_inlet_arbiter #(
    parameter int NUM_MACHINES = 4,
    parameter int FILL_TIMEOUT = 1000,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 10,
    localparam int ID_W        = (NUM_MACHINES > 1) ? $clog2(NUM_MACHINES) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_MACHINES-1:0] fill_req,
    input  logic [NUM_MACHINES-1:0] filled,
    input  logic [NUM_MACHINES-1:0] clear_fault,
    output logic [NUM_MACHINES-1:0] fill_grant,
    output logic [ID_W-1:0]         active_id,
    output logic                    busy,
    output logic [NUM_MACHINES-1:0] fault,
    output logic                    fault_pulse
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [NUM_MACHINES-1:0] ONE_HOT0 = {{(NUM_MACHINES-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST    = ID_W'(NUM_MACHINES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_e;

    state_e                  state_q;
    logic [NUM_MACHINES-1:0] grant_q;
    logic [ID_W-1:0]         id_q;
    logic [ID_W-1:0]         rr_q;
    logic                    busy_q;
    logic                    pulse_q;
    logic [CNT_W-1:0]        timer_q;
    logic [GAP_W-1:0]        gap_q;

    logic [NUM_MACHINES-1:0] elig;
    logic [NUM_MACHINES-1:0] fault_set;
    logic [ID_W-1:0]         pick_id_d;
    logic                    pick_vld_d;
    logic                    g_filled;
    logic                    g_req;
    logic                    g_timeout;
    logic                    g_fault_d;
    logic [ID_W-1:0]         rr_next_d;

    // Faulted machines drop out of arbitration until cleared.
    assign elig = fill_req & ~fault;

    // Round-robin pick: first eligible index scanning upward from rr_q with
    // wrap. Scanning the offsets downward lets the smallest offset win last.
    always_comb begin
        int idx;
        idx        = 0;
        pick_vld_d = 1'b0;
        pick_id_d  = '0;
        for (int k = NUM_MACHINES - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_MACHINES;
            if (elig[idx]) begin
                pick_vld_d = 1'b1;
                pick_id_d  = ID_W'(idx);
            end
        end
    end

    // Release conditions for the current holder, in priority order:
    // filled beats abort beats watchdog, so a fill that completes on the
    // last watchdog cycle is a clean completion.
    assign g_filled  = filled[id_q];
    assign g_req     = fill_req[id_q];
    assign g_timeout = (timer_q == TIMER_LAST);
    assign g_fault_d = (state_q == S_GRANT) && !g_filled && g_req && g_timeout;
    assign rr_next_d = (id_q == ID_LAST) ? '0 : id_q + 1'b1;

    // grant_q is the one-hot of the holder, so it doubles as the fault mask.
    assign fault_set = g_fault_d ? grant_q : '0;

    // Arbitration FSM with registered valve, id, busy and fault pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            timer_q <= '0;
            gap_q   <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        state_q <= S_GRANT;
                        grant_q <= ONE_HOT0 << pick_id_d;
                        id_q    <= pick_id_d;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
                S_GRANT: begin
                    if (!g_filled && g_req && !g_timeout) begin
                        timer_q <= timer_q + 1'b1;
                    end else begin
                        // Completion, abort or watchdog: drop the valve and
                        // move the pointer past the holder in every case.
                        state_q <= S_GAP;
                        grant_q <= '0;
                        id_q    <= '0;
                        rr_q    <= rr_next_d;
                        gap_q   <= '0;
                        pulse_q <= g_fault_d;
                    end
                end
                S_GAP: begin
                    // Valve stays shut while pressure settles; requests keep
                    // waiting and are picked up by the next IDLE evaluation.
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    id_q    <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // One sticky fault flag per machine.
    generate
        for (genvar i = 0; i < NUM_MACHINES; i++) begin : g_fault
            water_inlet_fault_cell u_cell (
                .clk     (clk),
                .reset_n (reset_n),
                .set_i   (fault_set[i]),
                .clr_i   (clear_fault[i]),
                .fault_o (fault[i])
            );
        end
    endgenerate

    assign fill_grant  = grant_q;
    assign active_id   = id_q;
    assign busy        = busy_q;
    assign fault_pulse = pulse_q;

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Directed bench for water_inlet_arbiter with N=4, FILL_TIMEOUT=8, GAP=2.
// A released grant is followed by GAP_CYCLES gap cycles plus one IDLE
// evaluation cycle, so zero-grant cycles between grants = GAP_CYCLES+1.
module tb_water_inlet_arbiter;

    localparam int N   = 4;
    localparam int FT  = 8;
    localparam int GAP = 2;
    localparam int CW  = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] fill_req = '0;
    logic [N-1:0] filled = '0;
    logic [N-1:0] clear_fault = '0;
    logic [N-1:0] fill_grant;
    logic [1:0]   active_id;
    logic         busy;
    logic [N-1:0] fault;
    logic         fault_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    water_inlet_arbiter #(
        .NUM_MACHINES (N),
        .FILL_TIMEOUT (FT),
        .GAP_CYCLES   (GAP),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fill_req    (fill_req),
        .filled      (filled),
        .clear_fault (clear_fault),
        .fill_grant  (fill_grant),
        .active_id   (active_id),
        .busy        (busy),
        .fault       (fault),
        .fault_pulse (fault_pulse)
    );

    // Invariants sampled on the falling edge.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (!$onehot0(fill_grant)) begin
                errors++;
                $display("FAIL onehot: fill_grant=%b required one-hot or zero", fill_grant);
            end
            checks++;
            if (fault_pulse && prev_pulse) begin
                errors++;
                $display("FAIL pulse_width: fault_pulse high two cycles, required one");
            end
        end
        prev_pulse = fault_pulse;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        fill_req    = '0;
        filled      = '0;
        clear_fault = '0;
        reset_n     = 1'b0;
        #2;
        reset_n     = 1'b1;
    endtask

    // Ticks until a grant appears; n = number of ticks (bounded).
    task automatic wait_grant(output int n);
        n = 0;
        while (fill_grant == '0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL wait_grant: no grant within 20 cycles");
        end
    endtask

    task automatic test_reset;
        fill_req = 4'b1111;
        reset_n  = 1'b0;
        tick();
        tick();
        checks++; if (fill_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want 0000", fill_grant); end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", active_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (fault !== 4'b0000) begin errors++; $display("FAIL rst_fault: got %b want 0000", fault); end
        checks++; if (fault_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse: got %b want 0", fault_pulse); end
        fill_req = '0;
        reset_n  = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        fill_req = 4'b0001;
        tick();
        checks++; if (fill_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", fill_grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        repeat (4) tick();
        checks++; if (fill_grant !== 4'b0001) begin errors++; $display("FAIL single_hold: got %b want 0001", fill_grant); end
        filled = 4'b0001;
        tick();
        checks++; if (fill_grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b want 0000", fill_grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy: got %b want 1", busy); end
        fill_req = '0;
        filled   = '0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy2: got %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        checks++; if (fault !== 4'b0000) begin errors++; $display("FAIL single_fault: got %b want 0000", fault); end
    endtask

    task automatic test_round_robin;
        int exp_order [4] = '{1, 2, 3, 0};
        int cur;
        int n;
        do_reset();
        fill_req = 4'b1111;
        tick();
        cur = 0;
        checks++; if (fill_grant !== 4'b0001) begin errors++; $display("FAIL rr_first: got %b want 0001", fill_grant); end
        for (int i = 0; i < 4; i++) begin
            filled = 4'b0001 << cur;
            tick();
            filled = '0;
            checks++; if (fill_grant !== 4'b0000) begin errors++; $display("FAIL rr_release%0d: got %b want 0000", i, fill_grant); end
            wait_grant(n);
            checks++; if (n != GAP + 1) begin errors++; $display("FAIL rr_gap%0d: got %0d zero cycles want %0d", i, n, GAP + 1); end
            cur = exp_order[i];
            checks++; if (fill_grant !== (4'b0001 << cur)) begin errors++; $display("FAIL rr_order%0d: got %b want machine %0d", i, fill_grant, cur); end
            checks++; if (active_id !== 2'(cur)) begin errors++; $display("FAIL rr_id%0d: got %0d want %0d", i, active_id, cur); end
        end
    endtask

    task automatic test_watchdog;
        int n;
        do_reset();
        fill_req = 4'b0100;
        tick();
        n = 0;
        while (fill_grant == 4'b0100 && n < 30) begin
            n++;
            tick();
        end
        checks++; if (n != FT) begin errors++; $display("FAIL wd_duration: got %0d want %0d", n, FT); end
        checks++; if (fault !== 4'b0100) begin errors++; $display("FAIL wd_fault: got %b want 0100", fault); end
        checks++; if (fault_pulse !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b want 1", fault_pulse); end
        tick();
        checks++; if (fault_pulse !== 1'b0) begin errors++; $display("FAIL wd_pulse_end: got %b want 0", fault_pulse); end
        // Machine 2 is faulted and the pointer sits at 3.
        fill_req = 4'b1111;
        wait_grant(n);
        checks++; if (fill_grant !== 4'b1000) begin errors++; $display("FAIL wd_rr_ptr: got %b want 1000", fill_grant); end
        fill_req = 4'b0100;
        tick();
        repeat (6) tick();
        checks++; if (fill_grant !== 4'b0000) begin errors++; $display("FAIL wd_ignored: got %b want 0000", fill_grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got %b want 0", busy); end
        clear_fault = 4'b0100;
        tick();
        clear_fault = '0;
        checks++; if (fault !== 4'b0000) begin errors++; $display("FAIL wd_clear: got %b want 0000", fault); end
        checks++; if (fill_grant !== 4'b0000) begin errors++; $display("FAIL wd_clear_nogrant: got %b want 0000", fill_grant); end
        tick();
        checks++; if (fill_grant !== 4'b0100) begin errors++; $display("FAIL wd_regrant: got %b want 0100", fill_grant); end
        checks++; if (active_id !== 2'd2) begin errors++; $display("FAIL wd_regrant_id: got %0d want 2", active_id); end
    endtask

    task automatic test_tie;
        do_reset();
        fill_req = 4'b0001;
        tick();
        repeat (FT - 1) tick();
        checks++; if (fill_grant !== 4'b0001) begin errors++; $display("FAIL tie_hold: got %b want 0001", fill_grant); end
        filled = 4'b0001;
        tick();
        checks++; if (fill_grant !== 4'b0000) begin errors++; $display("FAIL tie_release: got %b want 0000", fill_grant); end
        checks++; if (fault !== 4'b0000) begin errors++; $display("FAIL tie_fault: got %b want 0000", fault); end
        checks++; if (fault_pulse !== 1'b0) begin errors++; $display("FAIL tie_pulse: got %b want 0", fault_pulse); end
        filled   = '0;
        fill_req = '0;
    endtask

    task automatic test_abort;
        int n;
        do_reset();
        fill_req = 4'b0010;
        tick();
        checks++; if (fill_grant !== 4'b0010) begin errors++; $display("FAIL abort_grant: got %b want 0010", fill_grant); end
        fill_req = 4'b1010;
        filled   = 4'b1000;
        tick();
        checks++; if (fill_grant !== 4'b0010) begin errors++; $display("FAIL abort_undisturbed: got %b want 0010", fill_grant); end
        fill_req = 4'b1001;
        filled   = '0;
        tick();
        checks++; if (fill_grant !== 4'b0000) begin errors++; $display("FAIL abort_release: got %b want 0000", fill_grant); end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL abort_id: got %0d want 0", active_id); end
        wait_grant(n);
        checks++; if (n != GAP + 1) begin errors++; $display("FAIL abort_gap: got %0d want %0d", n, GAP + 1); end
        checks++; if (fill_grant !== 4'b1000) begin errors++; $display("FAIL abort_next: got %b want 1000", fill_grant); end
        checks++; if (active_id !== 2'd3) begin errors++; $display("FAIL abort_next_id: got %0d want 3", active_id); end
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset();
        fill_req = 4'b0100;
        tick();
        n = 0;
        while (fill_grant == 4'b0100 && n < 30) begin
            n++;
            tick();
        end
        checks++; if (fault !== 4'b0100) begin errors++; $display("FAIL rm_setup_fault: got %b want 0100", fault); end
        fill_req = 4'b1000;
        wait_grant(n);
        checks++; if (fill_grant !== 4'b1000) begin errors++; $display("FAIL rm_setup_grant: got %b want 1000", fill_grant); end
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (fill_grant !== 4'b0000) begin errors++; $display("FAIL rm_grant: got %b want 0000", fill_grant); end
        checks++; if (fault !== 4'b0000) begin errors++; $display("FAIL rm_fault: got %b want 0000", fault); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        reset_n  = 1'b1;
        fill_req = 4'b1001;
        tick();
        tick();
        checks++; if (fill_grant !== 4'b0001) begin errors++; $display("FAIL rm_rr_reset: got %b want 0001", fill_grant); end
        fill_req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_tie();
        test_abort();
        test_reset_mid();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
